imem_load_ctrl: RTL and testbench

- Boot-time sequencer for loading the instruction memory from the serial-to-parallel deserializer.
- Accepts each completed byte from the deserializer and requests the shared memory bus. After grant, it writes the byte to the next byte address of the instruction memory.
- Holds the CPU in reset until the programmed number of 32-bit instructions is written, then releases it.
- Flags byte overruns and serial-link timeouts.

---
 rtl/imem_load_pkg.sv | 45 ++++
 rtl/edge_detect.sv | 23 ++
 rtl/imem_load_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_imem_load_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Holds the sequencer state encoding and the state-class helpers used by the top.
package imem_load_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        REQ       = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4,
        ERROR     = 3'd5
    } state_t;

    localparam int unsigned BPW_DEFAULT     = 32'd4;
    localparam int unsigned TIMEOUT_DEFAULT = 32'd1024;

    // A load may only be (re)started from a resting state.
    function automatic logic can_start(input state_t s);
        logic v;
        case (s)
            IDLE, DONE, ERROR: v = 1'b1;
            default:           v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic is_busy(input state_t s);
        logic v;
        case (s)
            WAIT_BYTE, REQ, WRITE: v = 1'b1;
            default:               v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic owns_bus(input state_t s);
        logic v;
        case (s)
            REQ, WRITE: v = 1'b1;
            default:    v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for level-held valid signals.
// The pulse is high for exactly one cycle per 0->1 transition of i_level.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    // Delayed copy of the level, sampled every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot-time sequencer: writes deserialized bytes to consecutive instruction-memory
// addresses over the shared bus and holds the CPU in reset until the load completes.
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int unsigned N       = 32'd8,
    parameter int unsigned M       = 32'd32,
    parameter int unsigned BPW     = BPW_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    input  logic [15:0]  num_words,
    input  logic         sb_valid,
    input  logic [N-1:0] sb_data,
    input  logic         bus_grant,
    output logic         bus_req,
    output logic         mem_we,
    output logic [M-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         busy,
    output logic         load_done,
    output logic         overrun,
    output logic         timeout_err,
    output logic         cpu_rst
);

    localparam int unsigned TW = $clog2(TIMEOUT + 32'd1);

    state_t         r_state;
    state_t         w_next_state;
    logic           w_byte_stb;
    logic           w_start_ok;
    logic [M-1:0]   w_total_calc;
    logic [M-1:0]   w_addr_inc;
    logic           w_tmo_hit;

    logic [M-1:0]   r_addr;
    logic [M-1:0]   r_total;
    logic [TW-1:0]  r_tcnt;
    logic [N-1:0]   r_hold;
    logic           r_overrun;

    logic           r_bus_req;
    logic           r_mem_we;
    logic [M-1:0]   r_mem_addr;
    logic [N-1:0]   r_mem_wdata;
    logic           r_busy;
    logic           r_load_done;
    logic           r_timeout_err;
    logic           r_cpu_rst;

    edge_detect u_byte_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (sb_valid),
        .o_rise  (w_byte_stb)
    );

    assign w_start_ok   = load_start & can_start(r_state);
    assign w_total_calc = M'(num_words) * M'(BPW);
    assign w_addr_inc   = r_addr + {{(M-1){1'b0}}, 1'b1};
    assign w_tmo_hit    = (r_tcnt == TW'(TIMEOUT - 32'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; resting states share the restart rule.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (load_start) begin
                    if (w_total_calc == {M{1'b0}}) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = WAIT_BYTE;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            WAIT_BYTE: begin
                if (w_byte_stb) begin
                    w_next_state = REQ;
                end else if (w_tmo_hit) begin
                    w_next_state = ERROR;
                end else begin
                    w_next_state = WAIT_BYTE;
                end
            end
            REQ: begin
                if (bus_grant) begin
                    w_next_state = WRITE;
                end else begin
                    w_next_state = REQ;
                end
            end
            WRITE: begin
                if (w_addr_inc == r_total) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = WAIT_BYTE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Load datapath: address, target, timeout count, hold byte and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= {M{1'b0}};
            r_total   <= {M{1'b0}};
            r_tcnt    <= {TW{1'b0}};
            r_hold    <= {N{1'b0}};
            r_overrun <= 1'b0;
        end else if (w_start_ok) begin
            r_addr    <= {M{1'b0}};
            r_total   <= w_total_calc;
            r_tcnt    <= {TW{1'b0}};
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                WAIT_BYTE: begin
                    if (w_byte_stb) begin
                        r_hold <= sb_data;
                        r_tcnt <= {TW{1'b0}};
                    end else begin
                        r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                REQ: begin
                    // A byte arriving before the held one is written is lost.
                    if (w_byte_stb) begin
                        r_overrun <= 1'b1;
                    end
                end
                WRITE: begin
                    r_addr <= w_addr_inc;
                    if (w_byte_stb) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    // Outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= {M{1'b0}};
            r_mem_wdata   <= {N{1'b0}};
            r_busy        <= 1'b0;
            r_load_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cpu_rst     <= 1'b1;
        end else begin
            r_bus_req     <= owns_bus(w_next_state);
            r_mem_we      <= (w_next_state == WRITE);
            r_busy        <= is_busy(w_next_state);
            r_load_done   <= (w_next_state == DONE);
            r_timeout_err <= (w_next_state == ERROR);
            r_cpu_rst     <= (w_next_state != DONE);
            if (w_next_state == WRITE) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= r_hold;
            end
        end
    end

    assign bus_req     = r_bus_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign load_done   = r_load_done;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign cpu_rst     = r_cpu_rst;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed-plus-random bench for imem_load_ctrl; expected writes come from a
// simple address/byte model, observed writes from a bus monitor.
module tb_imem_load_ctrl;

    localparam int N       = 8;
    localparam int M       = 32;
    localparam int BPW     = 4;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start;
    logic [15:0]  num_words;
    logic         sb_valid;
    logic [N-1:0] sb_data;
    logic         bus_grant;
    logic         bus_req;
    logic         mem_we;
    logic [M-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         busy;
    logic         load_done;
    logic         overrun;
    logic         timeout_err;
    logic         cpu_rst;

    int errors = 0;
    int checks = 0;

    logic [M-1:0] got_addr[$];
    logic [N-1:0] got_data[$];
    logic [M-1:0] exp_addr[$];
    logic [N-1:0] exp_data[$];
    logic [M-1:0] m_addr;

    imem_load_ctrl #(.N(N), .M(M), .BPW(BPW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .num_words   (num_words),
        .sb_valid    (sb_valid),
        .sb_data     (sb_data),
        .bus_grant   (bus_grant),
        .bus_req     (bus_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .load_done   (load_done),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .cpu_rst     (cpu_rst)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [N-1:0] b);
        exp_addr.push_back(m_addr);
        exp_data.push_back(b);
        m_addr++;
    endtask

    task automatic load(input int nw);
        num_words  = 16'(nw);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_addr     = '0;
    endtask

    task automatic send(input logic [N-1:0] b, input int hold, input int gap, input bit accept);
        sb_data  = b;
        sb_valid = 1'b1;
        repeat (hold) tick();
        sb_valid = 1'b0;
        if (accept) model_accept(b);
        repeat (gap) tick();
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
            chk({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
        end
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_req"},     64'(bus_req),     64'(0));
        chk({tag, "_mem_we"},      64'(mem_we),      64'(0));
        chk({tag, "_mem_addr"},    64'(mem_addr),    64'(0));
        chk({tag, "_mem_wdata"},   64'(mem_wdata),   64'(0));
        chk({tag, "_busy"},        64'(busy),        64'(0));
        chk({tag, "_load_done"},   64'(load_done),   64'(0));
        chk({tag, "_overrun"},     64'(overrun),     64'(0));
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
        chk({tag, "_cpu_rst"},     64'(cpu_rst),     64'(1));
    endtask

    initial begin
        int cnt_req;
        int cnt_we;
        int nw;
        logic [N-1:0] b;

        rst        = 1'b1;
        load_start = 1'b0;
        num_words  = '0;
        sb_valid   = 1'b0;
        sb_data    = '0;
        bus_grant  = 1'b0;
        m_addr     = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Two words, bytes 0x11..0x88, grant always given.
        bus_grant = 1'b1;
        load(2);
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_cpu_rst", 64'(cpu_rst), 64'(1));
        for (int i = 1; i <= 7; i++) send(8'(i * 17), 1, 4, 1'b1);
        send(8'h88, 1, 1, 1'b1);
        chk("last_we", 64'(mem_we), 64'(1));
        chk("last_addr", 64'(mem_addr), 64'(7));
        tick();
        chk("done_load_done", 64'(load_done), 64'(1));
        chk("done_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("done_bus_req", 64'(bus_req), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
        compare_writes("seq8");

        // Grant withheld for 20 cycles after the first byte.
        load(1);
        bus_grant = 1'b0;
        b = 8'($urandom);
        send(b, 1, 0, 1'b1);
        cnt_req = 0;
        cnt_we  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req === 1'b1) cnt_req++;
            if (mem_we === 1'b1) cnt_we++;
            tick();
        end
        chk("stall_req_cycles", 64'(cnt_req), 64'(20));
        chk("stall_no_we", 64'(cnt_we), 64'(0));
        bus_grant = 1'b1;
        tick();
        chk("stall_we", 64'(mem_we), 64'(1));
        chk("stall_addr", 64'(mem_addr), 64'(0));
        chk("stall_data", 64'(mem_wdata), 64'(b));
        repeat (3) tick();
        for (int i = 0; i < 3; i++) send(8'($urandom), 1, 4, 1'b1);
        chk("stall_done", 64'(load_done), 64'(1));
        compare_writes("stall");

        // Second byte edge while waiting for the bus is dropped.
        load(1);
        bus_grant = 1'b0;
        send(8'hA5, 1, 1, 1'b1);
        send(8'h5A, 1, 1, 1'b0);
        chk("ovr_set", 64'(overrun), 64'(1));
        bus_grant = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) send(8'($urandom), 1, 4, 1'b1);
        chk("ovr_done", 64'(load_done), 64'(1));
        chk("ovr_sticky", 64'(overrun), 64'(1));
        compare_writes("ovr");
        load(1);
        chk("ovr_cleared", 64'(overrun), 64'(0));
        for (int i = 0; i < 4; i++) send(8'($urandom), 1, 4, 1'b1);
        compare_writes("ovr_reload");

        // Serial-link timeout and recovery.
        load(1);
        repeat (TIMEOUT - 20) tick();
        chk("tmo_not_yet", 64'(timeout_err), 64'(0));
        chk("tmo_still_busy", 64'(busy), 64'(1));
        repeat (30) tick();
        chk("tmo_err", 64'(timeout_err), 64'(1));
        chk("tmo_cpu_rst", 64'(cpu_rst), 64'(1));
        chk("tmo_busy", 64'(busy), 64'(0));
        load(1);
        chk("tmo_cleared", 64'(timeout_err), 64'(0));
        chk("tmo_restart_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 4; i++) send(8'($urandom), 1, 4, 1'b1);
        chk("tmo_reload_done", 64'(load_done), 64'(1));
        compare_writes("tmo");

        // A valid level held for five cycles is one byte.
        load(1);
        send(8'h3C, 5, 4, 1'b1);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1, 4, 1'b1);
        compare_writes("held");

        // Zero words completes immediately.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(0);
        chk("zero_done", 64'(load_done), 64'(1));
        chk("zero_cpu_rst", 64'(cpu_rst), 64'(0));
        chk("zero_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        compare_writes("zero");

        // Randomized loads with grant always given.
        for (int k = 0; k < 4; k++) begin
            nw = int'($urandom_range(1, 3));
            load(nw);
            for (int i = 0; i < nw * BPW; i++) begin
                send(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(2, 5)), 1'b1);
            end
            tick();
            chk("rand_done", 64'(load_done), 64'(1));
            chk("rand_cpu_rst", 64'(cpu_rst), 64'(0));
            compare_writes("rand");
        end

        // Reset asserted during a write.
        load(2);
        send(8'hC3, 1, 4, 1'b1);
        send(8'h7E, 1, 1, 1'b1);
        chk("rstw_in_write", 64'(mem_we), 64'(1));
        chk("rstw_addr", 64'(mem_addr), 64'(1));
        rst = 1'b1;
        tick();
        chk_reset_outputs("rstw");
        rst = 1'b0;
        tick();
        compare_writes("rstw_partial");
        load(1);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1, 4, 1'b1);
        chk("rstw_reload_done", 64'(load_done), 64'(1));
        compare_writes("rstw_reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
